// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the alu issue stage: opcodes, alu ctrl
// encodings, FSM state enum and the per-op hold latency lookup.
package alu_issue_pkg;

  localparam int XLEN       = 32;
  localparam int SIMPLE_LAT = 2;
  localparam int MUL_LAT    = 34;
  localparam int DIV_LAT    = 36;
  localparam int FLUSH_CYC  = 1;
  localparam int CNT_W      = 6;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // ctrl = {funct7[5], funct7[0], funct3}
  localparam logic [4:0] CTRL_ADD    = 5'b00000;
  localparam logic [4:0] CTRL_SUB    = 5'b10000;
  localparam logic [4:0] CTRL_SLL    = 5'b00001;
  localparam logic [4:0] CTRL_XOR    = 5'b00100;
  localparam logic [4:0] CTRL_SRL    = 5'b00101;
  localparam logic [4:0] CTRL_SRA    = 5'b10101;
  localparam logic [4:0] CTRL_OR     = 5'b00110;
  localparam logic [4:0] CTRL_AND    = 5'b00111;
  localparam logic [4:0] CTRL_MUL    = 5'b01000;
  localparam logic [4:0] CTRL_MULH   = 5'b01001;
  localparam logic [4:0] CTRL_MULHSU = 5'b01010;
  localparam logic [4:0] CTRL_MULHU  = 5'b01011;
  localparam logic [4:0] CTRL_DIV    = 5'b01100;
  localparam logic [4:0] CTRL_DIVU   = 5'b01101;
  localparam logic [4:0] CTRL_REM    = 5'b01110;
  localparam logic [4:0] CTRL_REMU   = 5'b01111;

  typedef enum logic [1:0] {IDLE, FLUSH, EXEC, DONE} state_t;

  // Cycles the alu inputs must stay stable before y is valid
  function automatic logic [CNT_W-1:0] hold_lat(input logic [4:0] ctrl);
    if (ctrl[3:2] == 2'b11) return CNT_W'(DIV_LAT);
    if (ctrl[3])            return CNT_W'(MUL_LAT);
    return CNT_W'(SIMPLE_LAT);
  endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Issue-stage bus: upstream instruction handshake, alu drive/return,
// downstream result handshake. master = surrounding logic, slave = stage.
interface alu_issue_if;
  import alu_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [4:0]      alu_ctrl;
  logic [XLEN-1:0] alu_y;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_rs1, in_rs2, alu_y, out_ready,
    input  in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs1, in_rs2, alu_y, out_ready,
    output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_result, out_illegal
  );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational RV32IM OP/OP-IMM decode into alu operands and ctrl.
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [4:0]      ctrl,
  output logic            illegal,
  output logic            is_div
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       unused_fields;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  // register specifiers are resolved upstream; only values arrive here
  assign unused_fields = ^{instr[19:15], instr[11:7]};

  // Operand select, ctrl build and legality check
  always_comb begin
    a       = rs1;
    b       = rs2;
    ctrl    = {f7[5], f7[0], f3};
    illegal = 1'b1;
    case (opc)
      OPC_OP:
        illegal = !(f7 == 7'b0000000 || f7 == 7'b0000001 ||
                    (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
      OPC_OP_IMM: begin
        b    = {{(XLEN-12){instr[31]}}, instr[31:20]};
        ctrl = {(f3 == 3'b101) & instr[30], 1'b0, f3};
        if (f3 == 3'b001)      illegal = (f7 != 7'b0000000);
        else if (f3 == 3'b101) illegal = !(f7 == 7'b0000000 || f7 == 7'b0100000);
        else                   illegal = 1'b0;
      end
      default: ;
    endcase
    // set-less-than has no alu encoding here
    if (!ctrl[3] && f3[2:1] == 2'b01) illegal = 1'b1;
    is_div = !illegal && (ctrl[3:2] == 2'b11);
  end
endmodule

// File: rtl/alu_issue.sv
// Issue/sequencing stage in front of the 32-bit alu. Holds a/b/ctrl for the
// op's latency, inserts a zero-operand flush before divides, captures y.
// Optional: ALU_ISSUE_DIV0_FAST_EN returns div/rem-by-zero results directly.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic clk,
  input  logic rst,
  alu_issue_if.slave bus
);
  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   a_q, b_q, alu_a, alu_b, result;
  logic [XLEN-1:0]   dec_a, dec_b;
  logic [4:0]        alu_ctrl, dec_ctrl;
  logic              illegal_q, dec_illegal, dec_is_div, fast_div0, accept;

  alu_issue_decode u_dec (
    .instr   (bus.in_instr),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .a       (dec_a),
    .b       (dec_b),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_div  (dec_is_div)
  );

  assign accept = (state == IDLE) && bus.in_valid;

`ifdef ALU_ISSUE_DIV0_FAST_EN
  assign fast_div0 = dec_is_div && (bus.in_rs2 == '0);
`else
  assign fast_div0 = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: flush only for divides; illegal/fast ops finish immediately
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (bus.in_valid) begin
               if (dec_illegal || fast_div0) nxt = DONE;
               else if (dec_is_div)          nxt = FLUSH;
               else                          nxt = EXEC;
             end
      FLUSH: if (cnt == '0) nxt = EXEC;
      EXEC:  if (cnt == '0) nxt = DONE;
      DONE:  if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: alu drive registers, hold counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0; a_q <= '0; b_q <= '0;
      alu_a <= '0; alu_b <= '0; alu_ctrl <= 5'b00000;
      result <= '0; illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (dec_illegal) begin
            result <= '0; illegal_q <= 1'b1;
          end else if (fast_div0) begin
            result <= dec_ctrl[1] ? bus.in_rs1 : '1;
            illegal_q <= 1'b0;
          end else if (dec_is_div) begin
            alu_ctrl <= dec_ctrl; alu_a <= '0; alu_b <= '0;
            a_q <= dec_a; b_q <= dec_b;
            cnt <= CNT_W'(FLUSH_CYC - 1);
          end else begin
            alu_ctrl <= dec_ctrl; alu_a <= dec_a; alu_b <= dec_b;
            cnt <= hold_lat(dec_ctrl) - 1'b1;
          end
        end
        FLUSH: if (cnt == '0) begin
          alu_a <= a_q; alu_b <= b_q;
          cnt <= hold_lat(alu_ctrl) - 1'b1;
        end else cnt <= cnt - 1'b1;
        EXEC: if (cnt == '0) begin
          result <= bus.alu_y; illegal_q <= 1'b0;
        end else cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.out_result  = result;
  assign bus.out_illegal = illegal_q;
  assign bus.alu_a       = alu_a;
  assign bus.alu_b       = alu_b;
  assign bus.alu_ctrl    = alu_ctrl;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a combinational stand-in for the alu.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_issue_if bus ();

  alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // stand-in alu (result only, ignores latency)
  always_comb begin
    case (bus.alu_ctrl)
      CTRL_ADD:  bus.alu_y = bus.alu_a + bus.alu_b;
      CTRL_SUB:  bus.alu_y = bus.alu_a - bus.alu_b;
      CTRL_SRA:  bus.alu_y = $signed(bus.alu_a) >>> bus.alu_b[4:0];
      CTRL_MUL:  bus.alu_y = bus.alu_a * bus.alu_b;
      CTRL_DIV:  bus.alu_y = (bus.alu_b == 0) ? '1 : 32'($signed(bus.alu_a) / $signed(bus.alu_b));
      CTRL_DIVU: bus.alu_y = (bus.alu_b == 0) ? '1 : bus.alu_a / bus.alu_b;
      CTRL_REMU: bus.alu_y = (bus.alu_b == 0) ? bus.alu_a : bus.alu_a % bus.alu_b;
      default:   bus.alu_y = bus.alu_a ^ bus.alu_b;
    endcase
  end

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // present one instruction from IDLE, return edges from accept to out_valid
  task automatic run_op(input logic [31:0] instr, input logic [31:0] rs1,
                        input logic [31:0] rs2, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = instr; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.out_result, bus.out_illegal} !== '0) begin
      errors++; $display("FAIL reset_regs: a=%h b=%h ctrl=%b res=%h ill=%b want all 0", bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.out_result, bus.out_illegal); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = rtype(7'b0000001, 3'b000); bus.in_rs1 = 32'd10000; bus.in_rs2 = 32'd8;
    tick(); bus.in_valid = 1'b0;
    repeat (5) tick();
    checks++; if (bus.alu_ctrl !== CTRL_MUL) begin errors++; $display("FAIL mid_mul_ctrl: got %b want %b", bus.alu_ctrl, CTRL_MUL); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_hs: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
    checks++; if (bus.alu_ctrl !== 5'b00000 || bus.alu_a !== 32'd0) begin errors++; $display("FAIL midrst_alu: ctrl=%b a=%h want 0/0", bus.alu_ctrl, bus.alu_a); end
    @(negedge clk); rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL postrst_hs: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_add;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = rtype(7'b0000000, 3'b000); bus.in_rs1 = 32'd10000; bus.in_rs2 = 32'd8;
    tick(); bus.in_valid = 1'b0;
    checks++; if (bus.alu_ctrl !== 5'b00000 || bus.alu_a !== 32'd10000 || bus.alu_b !== 32'd8 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL add_hold1: ctrl=%b a=%0d b=%0d ov=%b want 00000/10000/8/0", bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.out_valid); end
    tick();
    checks++; if (bus.alu_ctrl !== 5'b00000 || bus.alu_a !== 32'd10000 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL add_hold2: ctrl=%b a=%0d ov=%b want 00000/10000/0", bus.alu_ctrl, bus.alu_a, bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd10008 || bus.out_illegal !== 1'b0) begin
      errors++; $display("FAIL add_result: ov=%b res=%0d ill=%b want 1/10008/0", bus.out_valid, bus.out_result, bus.out_illegal); end
    tick();
  endtask

  task automatic test_imm;
    int lat;
    run_op(itype(12'hFF8, 3'b000), 32'd10000, 32'd0, lat);
    checks++; if (lat !== 3 || bus.out_result !== 32'd9992 || bus.alu_b !== 32'hFFFFFFF8) begin
      errors++; $display("FAIL addi: lat=%0d res=%0d b=%h want 3/9992/fffffff8", lat, bus.out_result, bus.alu_b); end
    tick();
    run_op(itype(12'h402, 3'b101), 32'h80000000, 32'd0, lat);
    checks++; if (bus.alu_ctrl !== 5'b10101 || bus.alu_b !== 32'h402 || bus.out_result !== 32'hE0000000) begin
      errors++; $display("FAIL srai: ctrl=%b b=%h res=%h want 10101/402/e0000000", bus.alu_ctrl, bus.alu_b, bus.out_result); end
    tick();
  endtask

  task automatic test_div;
    int n;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = rtype(7'b0000001, 3'b100); bus.in_rs1 = 32'd10000; bus.in_rs2 = 32'd8;
    tick(); bus.in_valid = 1'b0;
    checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_ctrl !== CTRL_DIV) begin
      errors++; $display("FAIL div_flush: a=%h b=%h ctrl=%b want 0/0/01100", bus.alu_a, bus.alu_b, bus.alu_ctrl); end
    tick(); n = 2;
    checks++; if (bus.alu_a !== 32'd10000 || bus.alu_b !== 32'd8) begin
      errors++; $display("FAIL div_operands: a=%0d b=%0d want 10000/8", bus.alu_a, bus.alu_b); end
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    checks++; if (n !== 38 || bus.out_result !== 32'd1250) begin
      errors++; $display("FAIL div_result: lat=%0d res=%0d want 38/1250", n, bus.out_result); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1250 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL div_stall%0d: ov=%b res=%0d ir=%b want 1/1250/0", i, bus.out_valid, bus.out_result, bus.in_ready); end
    end
    @(negedge clk); bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL div_release: ir=%b ov=%b want 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_mul;
    int lat;
    run_op(rtype(7'b0000001, 3'b000), 32'd10000, 32'd8, lat);
    checks++; if (lat !== 35 || bus.out_result !== 32'd80000) begin
      errors++; $display("FAIL mul: lat=%0d res=%0d want 35/80000", lat, bus.out_result); end
    tick();
  endtask

  task automatic test_illegal;
    int lat;
    run_op(rtype(7'b0000000, 3'b010), 32'd5, 32'd6, lat);
    checks++; if (lat !== 1 || bus.out_illegal !== 1'b1 || bus.out_result !== 32'd0) begin
      errors++; $display("FAIL slt: lat=%0d ill=%b res=%h want 1/1/0", lat, bus.out_illegal, bus.out_result); end
    checks++; if (bus.alu_ctrl !== CTRL_MUL || bus.alu_a !== 32'd10000 || bus.alu_b !== 32'd8) begin
      errors++; $display("FAIL slt_alu_hold: ctrl=%b a=%0d b=%0d want 01000/10000/8", bus.alu_ctrl, bus.alu_a, bus.alu_b); end
    tick();
    run_op(itype(12'h402, 3'b001), 32'd5, 32'd0, lat);
    checks++; if (lat !== 1 || bus.out_illegal !== 1'b1) begin
      errors++; $display("FAIL slli_f7: lat=%0d ill=%b want 1/1", lat, bus.out_illegal); end
    tick();
    run_op(rtype(7'b0100000, 3'b001), 32'd5, 32'd6, lat);
    checks++; if (lat !== 1 || bus.out_illegal !== 1'b1) begin
      errors++; $display("FAIL op_f7_sll: lat=%0d ill=%b want 1/1", lat, bus.out_illegal); end
    tick();
    run_op(rtype(7'b0100000, 3'b000), 32'd9, 32'd4, lat);
    checks++; if (lat !== 3 || bus.out_illegal !== 1'b0 || bus.out_result !== 32'd5) begin
      errors++; $display("FAIL sub: lat=%0d ill=%b res=%0d want 3/0/5", lat, bus.out_illegal, bus.out_result); end
    tick();
  endtask

  task automatic test_back_to_back;
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_instr = rtype(7'b0000000, 3'b000); bus.in_rs1 = 32'd1; bus.in_rs2 = 32'd2;
    tick(); tick(); tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_result !== 32'd3) begin
      errors++; $display("FAIL b2b_done: ov=%b ir=%b res=%0d want 1/0/3", bus.out_valid, bus.in_ready, bus.out_result); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_idle: ov=%b ir=%b want 0/1", bus.out_valid, bus.in_ready); end
    bus.in_rs2 = 32'd5;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept2: ir=%b want 0", bus.in_ready); end
    n = 1;
    while (!bus.out_valid && n < 100) begin tick(); n++; end
    checks++; if (n !== 3 || bus.out_result !== 32'd6) begin
      errors++; $display("FAIL b2b_second: lat=%0d res=%0d want 3/6", n, bus.out_result); end
    tick();
  endtask

  task automatic test_div0;
    int lat, exp_lat;
`ifdef ALU_ISSUE_DIV0_FAST_EN
    exp_lat = 1;
`else
    exp_lat = 38;
`endif
    run_op(rtype(7'b0000001, 3'b111), 32'd77, 32'd0, lat);
    checks++; if (lat !== exp_lat || bus.out_result !== 32'd77 || bus.out_illegal !== 1'b0) begin
      errors++; $display("FAIL remu_div0: lat=%0d res=%0d ill=%b want %0d/77/0", lat, bus.out_result, bus.out_illegal, exp_lat); end
    tick();
    run_op(rtype(7'b0000001, 3'b101), 32'd5, 32'd0, lat);
    checks++; if (lat !== exp_lat || bus.out_result !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL divu_div0: lat=%0d res=%h want %0d/ffffffff", lat, bus.out_result, exp_lat); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.out_ready = 1'b1;
    test_reset();
    test_reset_mid_op();
    test_add();
    test_imm();
    test_div();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_div0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
Issue/sequencing stage directly upstream of the 32-bit alu (ports a, b, ctrl[4:0], y, cout).
- Accepts one RV32IM OP/OP-IMM instruction with operand values over a valid/ready handshake.
- Decodes it into the alu's 5-bit ctrl and holds a/b/ctrl stable for the op's fixed latency.
- Inserts the zero-operand flush cycle the divider needs, then captures y and presents it downstream with valid/ready.

Parameters:
XLEN, 32, datapath width
SIMPLE_LAT, 2, cycles ctrl/a/b held for non-M ops before y sampled
MUL_LAT, 34, hold cycles for mul/mulh/mulhsu/mulhu
DIV_LAT, 36, hold cycles for div/divu/rem/remu (after flush)
FLUSH_CYC, 1, cycles a=b=0 driven before a div-class op

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_rs1  in  XLEN  rs1 value
in_rs2  in  XLEN  rs2 value
alu_a  out  XLEN  to alu a
alu_b  out  XLEN  to alu b
alu_ctrl  out  5  to alu ctrl
alu_y  in  XLEN  from alu y
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_result  out  XLEN  captured result
out_illegal  out  1  instruction not supported (qualified by out_valid)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous, active-high.
- Reset (async, any state incl. mid-op): state=IDLE, counter=0, in_ready=1, out_valid=0, out_result=0, out_illegal=0, alu_a=alu_b=0, alu_ctrl=5'b00000.
- Decode: ctrl={funct7[5], funct7[0], funct3}.
  - OP (0110011): legal if funct7 ∈ {0000000, 0100000 with funct3 000/101, 0000001}.
  - OP-IMM (0010011): b = sign-extended imm[11:0]; ctrl[3]=0; ctrl[4]=instr[30] only for funct3=101 (SRAI), else 0; SLLI/SRxI need imm[11:5] ∈ {0000000, 0100000 (SRAI only)}.
  - funct3 010/011 with ctrl[3]=0 (SLT/SLTU/SLTI/SLTIU): illegal.
  - Any other opcode: illegal.
- FSM states: IDLE, FLUSH, EXEC, DONE.
  - IDLE: in_ready=1. On in_valid: latch decode.
    - Illegal: go to DONE, out_result=0, out_illegal=1.
    - ctrl[3:2]=2'b11 (div class): go to FLUSH.
    - Else: go to EXEC with counter=lat-1.
  - FLUSH: alu_ctrl=latched ctrl, alu_a=alu_b=0 for FLUSH_CYC cycles, then EXEC with operands applied.
  - EXEC: drive latched a/b/ctrl unchanged; decrement counter. At counter==0, sample alu_y into out_result and go to DONE.
  - DONE: out_valid=1; out_result/out_illegal stable. When out_ready, go to IDLE.
- in_ready is high only in IDLE. DONE→IDLE and the next accept never share a cycle; max throughput is one op per lat+2 cycles.
- Latency (accept edge to out_valid): simple SIMPLE_LAT+1; mul MUL_LAT+1; div FLUSH_CYC+DIV_LAT+1; illegal 1.
- alu_a/alu_b/alu_ctrl hold their last values in DONE/IDLE. There is no combinational path from in_* to alu_*.
- cout is not consumed.

Optional Feature:
ALU_ISSUE_DIV0_FAST_EN
- Defined: a div-class op with rs2==0 skips FLUSH/EXEC and goes straight to DONE (latency 1).
  - div/divu: result 32'hFFFFFFFF.
  - rem/remu: result = rs1.
  - out_illegal=0.
- Undefined: div-by-zero runs the normal FLUSH+EXEC path and returns whatever alu_y gives.

Decomposition:
- Package alu_issue_pkg holds:
  - Opcode constants OPC_OP, OPC_OP_IMM.
  - The 16 ctrl encodings (CTRL_ADD=00000 … CTRL_SRA=10101, CTRL_DIV=01100 etc.).
  - State enum.
  - A function returning hold latency per ctrl.
- One combinational sub-module, alu_issue_decode: instr, rs1, rs2 → a, b, ctrl, illegal, is_div.

Test Plan:
- Reset mid-op: assert rst during EXEC of MUL → next cycle in_ready=1, out_valid=0, alu_ctrl=00000, alu_a=0.
- ADD x, rs1=10000, rs2=8, out_ready=1 → alu_ctrl=00000 held 2 cycles; out_valid 3 cycles after accept; out_result=10008.
- ADDI imm=-8 (12'hFF8), rs1=10000 → alu_b=32'hFFFFFFF8, result 9992. SRAI imm=0x402 → alu_ctrl=10101, alu_b=32'h402.
- DIV rs1=10000, rs2=8 → one cycle alu_a=alu_b=0, then 10000/8 for 36 cycles; out_result=1250. Hold out_ready=0 for 5 cycles: out_valid and result stable, in_ready=0.
- MUL 10000*8 → out_valid at accept+35, result 80000. Back-to-back in_valid: second accept only after DONE→IDLE.
- SLT (funct3=010, funct7=0) → out_valid next cycle, out_illegal=1, result 0, alu_* unchanged. With ALU_ISSUE_DIV0_FAST_EN: REMU rs1=77, rs2=0 → result 77, latency 1.
